// File: rtl/uart_tx_fifo.sv
`default_nettype none
// ============================================================================
// Module      : uart_tx_fifo
// Description : Buffered 8N1 UART transmitter. Bytes arrive over a
//               valid/ready handshake, are queued in a 2^DEPTH_LOG2-entry
//               FIFO and are serialized LSB first at DELAY_FRAMES clocks per
//               bit. Queued bytes are sent back to back with no idle gap.
// Ports       : clk      - system clock, rising edge
//               rst_n    - asynchronous active-low reset
//               wr_data  - byte to queue
//               wr_valid - producer offers wr_data this cycle
//               wr_ready - FIFO has room (count < depth)
//               uart_tx  - registered serial line, idle high
//               busy     - frame in progress or FIFO non-empty
//               count    - bytes queued, excluding the one being shifted
// Revision    : 1.0 - initial release
// ============================================================================
module uart_tx_fifo #(
    parameter int DELAY_FRAMES = 234,
    parameter int DEPTH_LOG2   = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [7:0]            wr_data,
    input  logic                  wr_valid,
    output logic                  wr_ready,
    output logic                  uart_tx,
    output logic                  busy,
    output logic [DEPTH_LOG2:0]   count
);

    localparam int c_DEPTH = 1 << DEPTH_LOG2;
    localparam int c_CYC_W = $clog2(DELAY_FRAMES);

    localparam logic [c_CYC_W-1:0]    c_LAST_CYC = c_CYC_W'(DELAY_FRAMES - 1);
    localparam logic [c_CYC_W-1:0]    c_CYC_ONE  = c_CYC_W'(1);
    localparam logic [DEPTH_LOG2-1:0] c_PTR_ONE  = DEPTH_LOG2'(1);
    localparam logic [DEPTH_LOG2:0]   c_CNT_ONE  = (DEPTH_LOG2 + 1)'(1);

    localparam logic [1:0] c_S_IDLE  = 2'd0;
    localparam logic [1:0] c_S_START = 2'd1;
    localparam logic [1:0] c_S_DATA  = 2'd2;
    localparam logic [1:0] c_S_STOP  = 2'd3;

    logic [7:0]            r_mem [c_DEPTH];
    logic [DEPTH_LOG2-1:0] r_wrPtr;
    logic [DEPTH_LOG2-1:0] r_rdPtr;
    logic [DEPTH_LOG2:0]   r_count;
    logic [1:0]            r_state;
    logic [c_CYC_W-1:0]    r_cycCnt;
    logic [2:0]            r_bitIdx;
    logic [7:0]            r_shift;
    logic                  r_tx;

    logic w_wrEn;
    logic w_notEmpty;
    logic w_bitEnd;
    logic w_pop;
    logic [7:0] w_head;

    // count never exceeds the depth, so its MSB alone marks "full".
    assign wr_ready   = ~r_count[DEPTH_LOG2];
    assign w_wrEn     = wr_valid & wr_ready;
    assign w_notEmpty = (r_count != '0);
    assign w_bitEnd   = (r_cycCnt == c_LAST_CYC);
    assign w_head     = r_mem[r_rdPtr];

    // A pop happens from IDLE, or at the final STOP cycle so the next START
    // follows with no idle gap.
    assign w_pop = w_notEmpty &&
                   ((r_state == c_S_IDLE) || ((r_state == c_S_STOP) && w_bitEnd));

    assign uart_tx = r_tx;
    assign busy    = (r_state != c_S_IDLE) || w_notEmpty;
    assign count   = r_count;

    // Storage carries no reset; its contents are don't-care after reset.
    always_ff @(posedge clk) begin
        if (w_wrEn) begin
            r_mem[r_wrPtr] <= wr_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wrPtr <= '0;
            r_rdPtr <= '0;
            r_count <= '0;
        end else begin
            if (w_wrEn) begin
                r_wrPtr <= r_wrPtr + c_PTR_ONE;
            end
            if (w_pop) begin
                r_rdPtr <= r_rdPtr + c_PTR_ONE;
            end
            case ({w_wrEn, w_pop})
                2'b10:   r_count <= r_count + c_CNT_ONE;
                2'b01:   r_count <= r_count - c_CNT_ONE;
                default: r_count <= r_count;
            endcase
        end
    end

    // The line value is computed for the state being entered so uart_tx is
    // a clean register output aligned with the state change.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= c_S_IDLE;
            r_cycCnt <= '0;
            r_bitIdx <= '0;
            r_shift  <= '0;
            r_tx     <= 1'b1;
        end else begin
            case (r_state)
                c_S_IDLE: begin
                    r_cycCnt <= '0;
                    r_tx     <= 1'b1;
                    if (w_pop) begin
                        r_shift <= w_head;
                        r_state <= c_S_START;
                        r_tx    <= 1'b0;
                    end
                end
                c_S_START: begin
                    if (w_bitEnd) begin
                        r_cycCnt <= '0;
                        r_bitIdx <= '0;
                        r_state  <= c_S_DATA;
                        r_tx     <= r_shift[0];
                    end else begin
                        r_cycCnt <= r_cycCnt + c_CYC_ONE;
                    end
                end
                c_S_DATA: begin
                    if (w_bitEnd) begin
                        r_cycCnt <= '0;
                        if (r_bitIdx == 3'd7) begin
                            r_state <= c_S_STOP;
                            r_tx    <= 1'b1;
                        end else begin
                            r_bitIdx <= r_bitIdx + 3'd1;
                            r_tx     <= r_shift[r_bitIdx + 3'd1];
                        end
                    end else begin
                        r_cycCnt <= r_cycCnt + c_CYC_ONE;
                    end
                end
                c_S_STOP: begin
                    if (w_bitEnd) begin
                        r_cycCnt <= '0;
                        if (w_pop) begin
                            r_shift <= w_head;
                            r_state <= c_S_START;
                            r_tx    <= 1'b0;
                        end else begin
                            r_state <= c_S_IDLE;
                            r_tx    <= 1'b1;
                        end
                    end else begin
                        r_cycCnt <= r_cycCnt + c_CYC_ONE;
                    end
                end
                default: begin
                    r_state  <= c_S_IDLE;
                    r_cycCnt <= '0;
                    r_tx     <= 1'b1;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_uart_tx_fifo.sv
`default_nettype none
// ============================================================================
// Module      : tb_uart_tx_fifo
// Description : Scoreboard bench for uart_tx_fifo (DELAY_FRAMES=4,
//               DEPTH_LOG2=2). Accepted bytes are queued as expectations; a
//               line monitor decodes each frame and compares it to the queue.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_uart_tx_fifo;

    localparam int c_DF    = 4;
    localparam int c_DL2   = 2;
    localparam int c_FRAME = 10 * c_DF;

    logic             clk;
    logic             rst_n;
    logic [7:0]       wr_data;
    logic             wr_valid;
    logic             wr_ready;
    logic             uart_tx;
    logic             busy;
    logic [c_DL2:0]   count;

    uart_tx_fifo #(
        .DELAY_FRAMES (c_DF),
        .DEPTH_LOG2   (c_DL2)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .wr_data  (wr_data),
        .wr_valid (wr_valid),
        .wr_ready (wr_ready),
        .uart_tx  (uart_tx),
        .busy     (busy),
        .count    (count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int         cyc = 0;
    int         nChecks = 0;
    int         nFails = 0;
    logic [7:0] expQ[$];
    int         frameStarts[$];
    int         frameCount = 0;
    bit         inFrame = 1'b0;
    int         maxCount = 0;
    bit         sawFull = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (int'(count) > maxCount) maxCount <= int'(count);
        if (count == 3'd4 && !wr_ready) sawFull <= 1'b1;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        nChecks++;
        if (act !== exp) begin
            nFails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Line monitor: a low sample while idle starts a frame; all 40 cycles
    // are captured so framing and exact bit length are verified.
    initial begin : monitor
        logic [c_FRAME-1:0] samp;
        logic [7:0]         got;
        logic [7:0]         exp;
        bit                 aborted;
        bit                 framing;
        int                 start;
        forever begin
            @(negedge clk);
            if (rst_n && uart_tx == 1'b0) begin
                inFrame = 1'b1;
                aborted = 1'b0;
                start   = cyc;
                for (int s = 0; s < c_FRAME; s++) begin
                    if (s > 0) @(negedge clk);
                    if (!rst_n) begin
                        aborted = 1'b1;
                        break;
                    end
                    samp[s] = uart_tx;
                end
                if (!aborted) begin
                    framing = (samp[0] == 1'b0) && (samp[c_FRAME-c_DF] == 1'b1);
                    for (int b = 0; b < 10; b++)
                        for (int k = 1; k < c_DF; k++)
                            if (samp[b*c_DF+k] !== samp[b*c_DF]) framing = 1'b0;
                    for (int i = 0; i < 8; i++) got[i] = samp[(i+1)*c_DF];
                    frameStarts.push_back(start);
                    frameCount++;
                    check("frame_format", 32'(framing), 32'd1);
                    if (expQ.size() == 0) begin
                        check("unexpected_frame", 32'(got), 32'hFFFF_FFFF);
                    end else begin
                        exp = expQ.pop_front();
                        check("frame_byte", 32'(got), 32'(exp));
                    end
                end
                inFrame = 1'b0;
            end
        end
    end

    // Called just after a negedge; returns at the negedge after acceptance.
    task automatic sendByte(input logic [7:0] b, output int acc);
        int n = 0;
        acc      = -1;
        wr_data  = b;
        wr_valid = 1'b1;
        while (!wr_ready && n < 400) begin
            @(negedge clk);
            n++;
        end
        if (!wr_ready) begin
            check("send_timeout", 32'(n), 32'd0);
            wr_valid = 1'b0;
        end else begin
            expQ.push_back(b);
            acc = cyc + 1;
            @(negedge clk);
            wr_valid = 1'b0;
        end
    endtask

    task automatic waitDrain(input int bound);
        int n = 0;
        while ((busy || inFrame || expQ.size() != 0) && n < bound) begin
            @(negedge clk);
            n++;
        end
        check("drain_done", 32'(n < bound), 32'd1);
    endtask

    task automatic applyReset();
        #2 rst_n = 1'b0;
        expQ.delete();
        #1;
        check("rst_uart_tx", 32'(uart_tx), 32'd1);
        check("rst_wr_ready", 32'(wr_ready), 32'd1);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_count", 32'(count), 32'd0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        frameStarts.delete();
    endtask

    initial begin : watchdog
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin : stimulus
        int acc, acc2, fc0, n;
        bit bad;
        rst_n    = 1'b1;
        wr_valid = 1'b0;
        wr_data  = 8'h00;
        @(negedge clk);
        applyReset();

        // 1: single byte 0x55
        sendByte(8'h55, acc);
        check("t1_busy_after_write", 32'(busy), 32'd1);
        check("t1_count_after_write", 32'(count), 32'd1);
        n = 0;
        while (busy && n < 200) begin
            @(negedge clk);
            n++;
        end
        check("t1_busy_fall_cycle", 32'(cyc), 32'(acc + 1 + c_FRAME));
        check("t1_frames", 32'(frameStarts.size()), 32'd1);
        if (frameStarts.size() == 1)
            check("t1_start_latency", 32'(frameStarts[0]), 32'(acc + 1));
        waitDrain(200);

        // 2: back-to-back 0xA3, 0x0F
        frameStarts.delete();
        sendByte(8'hA3, acc);
        sendByte(8'h0F, acc2);
        check("t2_consecutive_accept", 32'(acc2), 32'(acc + 1));
        waitDrain(400);
        check("t2_frames", 32'(frameStarts.size()), 32'd2);
        if (frameStarts.size() == 2) begin
            check("t2_first_start", 32'(frameStarts[0]), 32'(acc + 1));
            check("t2_no_gap", 32'(frameStarts[1] - frameStarts[0]), 32'(c_FRAME));
        end

        // 3: hold valid with incrementing bytes until FIFO fills
        for (int i = 0; i < 12; i++) sendByte(8'(i), acc);
        check("t3_saw_full", 32'(sawFull), 32'd1);
        check("t3_max_count", 32'(maxCount), 32'd4);
        waitDrain(2000);

        // 4: writes while full are ignored
        for (int i = 0; i < 5; i++) sendByte(8'h60 + 8'(i), acc);
        check("t4_full_count", 32'(count), 32'd4);
        check("t4_full_ready", 32'(wr_ready), 32'd0);
        for (int p = 0; p < 3; p++) begin
            if (!wr_ready) begin
                wr_data  = 8'hEE;
                wr_valid = 1'b1;
                @(negedge clk);
                wr_valid = 1'b0;
                check("t4_count_stays_full", 32'(count), 32'd4);
            end
        end
        waitDrain(1000);

        // 5: 20 bytes with random gaps, pointers wrap five times
        fc0 = frameCount;
        for (int i = 0; i < 20; i++) begin
            repeat ($urandom_range(0, 3)) @(negedge clk);
            sendByte(8'h10 + 8'(i), acc);
        end
        waitDrain(2000);
        check("t5_frame_total", 32'(frameCount - fc0), 32'd20);

        // 6: reset during DATA bit 3 with two bytes queued
        sendByte(8'hF0, acc);
        sendByte(8'h11, acc2);
        sendByte(8'h22, acc2);
        while (cyc < acc + 18) @(negedge clk);
        check("t6_queued", 32'(count), 32'd2);
        check("t6_line_bit3", 32'(uart_tx), 32'd0);
        fc0 = frameCount;
        #2 rst_n = 1'b0;
        expQ.delete();
        #1;
        check("t6_async_line_high", 32'(uart_tx), 32'd1);
        check("t6_async_count", 32'(count), 32'd0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        bad = 1'b0;
        repeat (100) begin
            @(negedge clk);
            if (uart_tx !== 1'b1 || busy !== 1'b0) bad = 1'b1;
        end
        check("t6_quiet_after_reset", 32'(bad), 32'd0);
        check("t6_no_new_frames", 32'(frameCount), 32'(fc0));

        $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
        $finish;
    end

endmodule
`default_nettype wire
